// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: fetch-redirect handshake between the trap controller and fetch.
// The master drives the request and target; the slave (fetch) returns ready.
interface trap_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller. Prioritises exceptions and enabled
// interrupts at the retire boundary, commits mepc/mcause/mtval and MIE/MPIE,
// handles mret, and requests a fetch redirect over trap_ctrl_if.
// Optional feature: TRAP_VECTORED_EN selects vectored interrupt targets when
// mtvec_csr[1:0] == 2'b01; without it every trap goes to the mtvec base.
module trap_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NUM_LOCAL_IRQ = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    input  logic [XLEN-1:0]          pc,
    input  logic [31:0]              instr,
    input  logic [XLEN-1:0]          fault_addr,
    input  logic                     i_misaligned,
    input  logic                     illegal_i,
    input  logic                     ebreak,
    input  logic                     ecall_m,
    input  logic                     s_misaligned,
    input  logic                     l_misaligned,
    input  logic                     mret,
    input  logic                     irq_sw,
    input  logic                     irq_timer,
    input  logic                     irq_ext,
    input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] irq_local,
    input  logic [XLEN-1:0]          mie_csr,
    input  logic [XLEN-1:0]          mtvec_csr,
    output logic                     flush,
    output logic                     busy,
    trap_ctrl_if.master              redir,
    output logic [XLEN-1:0]          mepc,
    output logic [XLEN-1:0]          mcause,
    output logic [XLEN-1:0]          mtval,
    output logic                     mstatus_mie,
    output logic                     mstatus_mpie
);

    typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] trap_pc_q;

    logic            int_pend;
    logic [4:0]      int_cause;
    logic            exc_any;
    logic [4:0]      exc_cause;
    logic [XLEN-1:0] exc_tval;
    logic            take_int;
    logic            evt_ok;
    logic            trap;
    logic            mret_ok;
    logic [4:0]      cause_sel;
    logic [XLEN-1:0] mcause_d;
    logic [XLEN-1:0] target;
    logic            unused_bits;

    assign unused_bits = ^{mie_csr, irq_local, mtvec_csr[1:0]};

    // Highest-priority enabled interrupt; later assignments override earlier ones
    always_comb begin
        int_pend  = 1'b0;
        int_cause = '0;
        for (int unsigned k = 0; k < NUM_LOCAL_IRQ; k++) begin
            if (irq_local[k] && mie_csr[16+k]) begin
                int_pend  = 1'b1;
                int_cause = 5'(16 + k);
            end
        end
        if (irq_timer && mie_csr[7]) begin
            int_pend  = 1'b1;
            int_cause = 5'd7;
        end
        if (irq_sw && mie_csr[3]) begin
            int_pend  = 1'b1;
            int_cause = 5'd3;
        end
        if (irq_ext && mie_csr[11]) begin
            int_pend  = 1'b1;
            int_cause = 5'd11;
        end
    end

    // Highest-priority synchronous exception and its mtval
    always_comb begin
        exc_any   = 1'b1;
        exc_cause = '0;
        exc_tval  = '0;
        if (i_misaligned) begin
            exc_cause = 5'd0;
            exc_tval  = fault_addr;
        end else if (illegal_i) begin
            exc_cause = 5'd2;
            exc_tval  = XLEN'(instr);
        end else if (ebreak) begin
            exc_cause = 5'd3;
            exc_tval  = pc;
        end else if (ecall_m) begin
            exc_cause = 5'd11;
        end else if (s_misaligned) begin
            exc_cause = 5'd6;
            exc_tval  = fault_addr;
        end else if (l_misaligned) begin
            exc_cause = 5'd4;
            exc_tval  = fault_addr;
        end else begin
            exc_any   = 1'b0;
        end
    end

    // Event arbitration, committed cause and trap target
    always_comb begin
        evt_ok    = (state_q == IDLE) && instr_valid;
        take_int  = mstatus_mie && int_pend;
        trap      = evt_ok && (take_int || exc_any);
        mret_ok   = evt_ok && mret && !trap;
        cause_sel = take_int ? int_cause : exc_cause;
        mcause_d  = XLEN'(cause_sel);
        mcause_d[XLEN-1] = take_int;
        target    = {mtvec_csr[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (take_int && (mtvec_csr[1:0] == 2'b01)) begin
            target = {mtvec_csr[XLEN-1:2], 2'b00} + (XLEN'(cause_sel) << 2);
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and redirect outputs; flush is masked so reset forces it low
    always_comb begin
        state_d              = state_q;
        flush                = trap && rst_n;
        busy                 = (state_q != IDLE);
        redir.redirect_valid = (state_q != IDLE);
        redir.redirect_pc    = (state_q == RETURN) ? mepc : trap_pc_q;
        case (state_q)
            IDLE: begin
                if (trap) begin
                    state_d = ENTER;
                end else if (mret_ok) begin
                    state_d = RETURN;
                end
            end
            ENTER, RETURN: begin
                if (redir.redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Trap CSR commit on trap entry and mret
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            trap_pc_q    <= '0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (trap) begin
            mepc         <= {pc[XLEN-1:2], 2'b00};
            mcause       <= mcause_d;
            mtval        <= take_int ? '0 : exc_tval;
            trap_pc_q    <= target;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_ok) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end
    end

endmodule
